// File: rtl/display_rd_frame_sched.sv
// display_rd_frame_sched: vsync-paced, credit-throttled burst read scheduler for a triple-buffered frame store
module display_rd_frame_sched #(
   parameter int          FRAME_WIDTH    = 540,
   parameter int          FRAME_HEIGHT   = 540,
   parameter int          PIX_PER_BEAT   = 2,
   parameter int          BURST_BEATS    = 64,
   parameter int          BYTES_PER_BEAT = 8,
   parameter logic [31:0] BUF0_BASE      = 32'h0100_0000,
   parameter logic [31:0] BUF_STRIDE     = 32'h0020_0000,
   parameter int          FIFO_DEPTH     = 1024,
   parameter int          FIFO_MARGIN    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          disp_vs,
   input  logic                          wr_frame_done,
   input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   input  logic                          dma_rbeat,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [31:0]                   cmd_addr,
   output logic [15:0]                   cmd_len,
   output logic [1:0]                    wr_buf_sel,
   output logic [1:0]                    rd_buf_sel,
   output logic                          frame_active,
   output logic [15:0]                   rd_frame_cnt,
   output logic                          err_overrun,
   output logic                          err_credit
);
   localparam logic [31:0] FRAME_BEATS = 32'(FRAME_WIDTH * FRAME_HEIGHT / PIX_PER_BEAT);
   localparam logic [32:0] CREDIT_MAX  = 33'(FIFO_DEPTH - FIFO_MARGIN);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_VS = 3'd1;
   localparam logic [2:0] S_CREDIT  = 3'd2;
   localparam logic [2:0] S_ISSUE   = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;

   logic [2:0]  state;
   logic        vs_d, pending, latest_valid;
   logic [1:0]  latest, rd_next;
   logic [31:0] addr, remaining, outstanding, rem_after;
   logic [15:0] len;
   logic        vs_start, frame_start, hs, credit_ok, busy;

   always_comb begin
      vs_start    = vs_d & ~disp_vs;
      hs          = cmd_valid & cmd_ready;
      busy        = (state == S_CREDIT) | (state == S_ISSUE) | (state == S_DRAIN);
      len         = remaining < 32'(BURST_BEATS) ? remaining[15:0] : 16'(BURST_BEATS);
      rem_after   = remaining - 32'(cmd_len);
      credit_ok   = 33'(fifo_level) + 33'(outstanding) + 33'(len) <= CREDIT_MAX;
      frame_start = enable & (((state == S_WAIT_VS) & vs_start) |
                    ((state == S_DRAIN) & (outstanding == 32'd0) & (pending | vs_start)));
      rd_next     = !frame_start ? rd_buf_sel : wr_frame_done ? wr_buf_sel :
                    latest_valid ? latest : rd_buf_sel;
   end

   // A coincident write-done and frame start hands the just-written buffer straight to the reader
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_buf_sel   <= 2'd0;
         rd_buf_sel   <= 2'd2;
         latest       <= 2'd1;
         latest_valid <= 1'b0;
      end else if (wr_frame_done & frame_start) begin
         rd_buf_sel   <= wr_buf_sel;
         wr_buf_sel   <= rd_buf_sel;
         latest_valid <= 1'b0;
      end else if (wr_frame_done) begin
         wr_buf_sel   <= latest;
         latest       <= wr_buf_sel;
         latest_valid <= 1'b1;
      end else if (frame_start & latest_valid) begin
         rd_buf_sel   <= latest;
         latest       <= rd_buf_sel;
         latest_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         vs_d         <= 1'b0;
         pending      <= 1'b0;
         addr         <= 32'd0;
         remaining    <= 32'd0;
         outstanding  <= 32'd0;
         cmd_valid    <= 1'b0;
         cmd_addr     <= 32'd0;
         cmd_len      <= 16'd0;
         frame_active <= 1'b0;
         rd_frame_cnt <= 16'd0;
         err_overrun  <= 1'b0;
         err_credit   <= 1'b0;
      end else begin
         vs_d        <= disp_vs;
         outstanding <= outstanding + (hs ? 32'(cmd_len) : 32'd0) -
                        {31'd0, (dma_rbeat && (outstanding != 32'd0))};
         if (dma_rbeat && (outstanding == 32'd0)) err_credit <= 1'b1;
         if (vs_start && busy) begin
            err_overrun <= 1'b1;
            pending     <= 1'b1;
         end
         if (frame_start) begin
            addr         <= BUF0_BASE + 32'(rd_next) * BUF_STRIDE;
            remaining    <= FRAME_BEATS;
            frame_active <= 1'b1;
            pending      <= 1'b0;
            state        <= S_CREDIT;
         end else begin
            case (state)
               S_IDLE:    if (enable) state <= S_WAIT_VS;
               S_WAIT_VS: if (!enable) state <= S_IDLE;
               S_CREDIT:
                  if (vs_start || !enable) state <= S_DRAIN;
                  else if (credit_ok) begin
                     cmd_valid <= 1'b1;
                     cmd_addr  <= addr;
                     cmd_len   <= len;
                     state     <= S_ISSUE;
                  end
               S_ISSUE:
                  if (cmd_ready) begin
                     cmd_valid <= 1'b0;
                     remaining <= rem_after;
                     addr      <= addr + 32'(cmd_len) * 32'(BYTES_PER_BEAT);
                     state     <= (rem_after == 32'd0 || !enable || pending || vs_start) ? S_DRAIN : S_CREDIT;
                  end
               S_DRAIN:
                  if (outstanding == 32'd0) begin
                     frame_active <= 1'b0;
                     pending      <= 1'b0;
                     if (remaining == 32'd0 && !pending && !vs_start) rd_frame_cnt <= rd_frame_cnt + 16'd1;
                     state <= enable ? S_WAIT_VS : S_IDLE;
                  end
               default:   state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_display_rd_frame_sched.sv
// tb_display_rd_frame_sched: randomized bench with a frame/buffer reference model for display_rd_frame_sched
module tb_display_rd_frame_sched;
   localparam int          FW     = 40;
   localparam int          FH     = 13;
   localparam int          FB     = FW * FH / 2;
   localparam int          BURST  = 64;
   localparam logic [31:0] BASE   = 32'h0100_0000;
   localparam logic [31:0] STRIDE = 32'h0020_0000;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, disp_vs = 1'b0, wr_frame_done = 1'b0;
   logic        dma_rbeat = 1'b0, cmd_ready = 1'b0;
   logic [10:0] fifo_level = 11'd0;
   logic        cmd_valid, frame_active, err_overrun, err_credit;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len, rd_frame_cnt;
   logic [1:0]  wr_buf_sel, rd_buf_sel;

   display_rd_frame_sched #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .disp_vs(disp_vs), .wr_frame_done(wr_frame_done),
      .fifo_level(fifo_level), .dma_rbeat(dma_rbeat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel),
      .frame_active(frame_active), .rd_frame_cnt(rd_frame_cnt), .err_overrun(err_overrun),
      .err_credit(err_credit)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          pend, exp_rem, exp_cnt, n_cmds, rdy_mode;
   bit          fifo_rand, restart;
   logic [31:0] exp_addr;
   int          m_wr, m_rd, m_lat;
   bit          m_lv;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_frame();
      exp_addr = BASE + 32'(m_rd) * STRIDE;
      exp_rem  = FB;
   endtask

   // Buffer ownership: "latest" is the newest complete camera frame not yet shown
   task automatic model_bufs(input bit done, input bit fs);
      int t;
      if (done && fs) begin
         t = m_rd; m_rd = m_wr; m_wr = t; m_lv = 0;
      end else if (done) begin
         t = m_wr; m_wr = m_lat; m_lat = t; m_lv = 1;
      end else if (fs && m_lv) begin
         t = m_rd; m_rd = m_lat; m_lat = t; m_lv = 0;
      end
   endtask

   task automatic step(input bit done = 0, input bit fs = 0, input bit ovr = 0);
      int l;
      wr_frame_done = done;
      cmd_ready = (rdy_mode == 2) || (rdy_mode == 1 && $urandom_range(0, 3) != 0);
      dma_rbeat = (pend > 0) && ($urandom_range(0, 3) != 0);
      if (dma_rbeat) pend--;
      if (fifo_rand) fifo_level = 11'($urandom_range(0, 900));
      if (cmd_valid && cmd_ready) begin
         l = exp_rem < BURST ? exp_rem : BURST;
         chk("cmd_addr", cmd_addr, exp_addr);
         chk("cmd_len", 32'(cmd_len), 32'(l));
         n_cmds++;
         pend     += l;
         exp_rem  -= l;
         exp_addr += 32'(l * 8);
         if (exp_rem == 0 && !restart) exp_cnt++;
         if (restart) begin
            restart = 0;
            load_frame();
         end
      end
      model_bufs(done, fs);
      if (fs) begin
         if (ovr) restart = 1;
         else load_frame();
      end
      @(negedge clk);
      wr_frame_done = 1'b0;
   endtask

   task automatic vs_pulse(input bit done, input bit ovr);
      disp_vs = 1'b1;
      step();
      disp_vs = 1'b0;
      step(done, 1, ovr);
   endtask

   task automatic wait_idle(input bit rand_done);
      int n = 0;
      while ((frame_active || pend > 0) && n < 5000) begin
         step(rand_done && $urandom_range(0, 39) == 0);
         n++;
      end
      chk("frame_timeout", 32'(n < 5000), 32'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!cmd_valid && n < 200) begin
         step();
         n++;
      end
      chk("cmd_valid_timeout", 32'(cmd_valid), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; disp_vs = 1'b0; wr_frame_done = 1'b0;
      dma_rbeat = 1'b0; cmd_ready = 1'b0; fifo_level = 11'd0;
      pend = 0; exp_rem = 0; exp_addr = 0; exp_cnt = 0; n_cmds = 0; restart = 0;
      rdy_mode = 1; fifo_rand = 0;
      m_wr = 0; m_rd = 2; m_lat = 1; m_lv = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_cmd_addr"}, cmd_addr, 32'd0);
      chk({tag, "_cmd_len"}, 32'(cmd_len), 32'd0);
      chk({tag, "_wr_buf_sel"}, 32'(wr_buf_sel), 32'd0);
      chk({tag, "_rd_buf_sel"}, 32'(rd_buf_sel), 32'd2);
      chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
      chk({tag, "_rd_frame_cnt"}, 32'(rd_frame_cnt), 32'd0);
      chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
      chk({tag, "_err_credit"}, 32'(err_credit), 32'd0);
   endtask

   task automatic chk_frame_end(input string tag);
      chk({tag, "_rd_buf_sel"}, 32'(rd_buf_sel), 32'(m_rd));
      chk({tag, "_wr_buf_sel"}, 32'(wr_buf_sel), 32'(m_wr));
      chk({tag, "_frame_cnt"}, 32'(rd_frame_cnt), 32'(exp_cnt));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk_reset_outputs("reset");
      enable = 1'b1;
      fifo_rand = 1;
      repeat (3) step();

      // first frame from reset: reads buffer 2, five bursts ending in a short one
      n_cmds = 0;
      vs_pulse(0, 0);
      chk("first_rd_buf", 32'(rd_buf_sel), 32'(m_rd));
      wait_idle(0);
      chk("burst_count", 32'(n_cmds), 32'((FB + BURST - 1) / BURST));
      chk_frame_end("frame1");

      // credit throttle
      fifo_rand = 0;
      fifo_level = 11'd950;
      vs_pulse(0, 0);
      repeat (5) step();
      chk("throttle_hold", 32'(cmd_valid), 32'd0);
      fifo_level = 11'd944;
      step();
      chk("throttle_release", 32'(cmd_valid), 32'd1);
      fifo_rand = 1;
      wait_idle(0);
      chk_frame_end("throttle");

      // rotation, then a repeated frame
      step(1);
      chk("rot_wr_after_done", 32'(wr_buf_sel), 32'(m_wr));
      vs_pulse(0, 0);
      chk_frame_end("rot_start");
      wait_idle(0);
      vs_pulse(0, 0);
      chk("repeat_rd_buf", 32'(rd_buf_sel), 32'(m_rd));
      wait_idle(0);
      chk_frame_end("repeat");

      // randomized frames with write completions at arbitrary times
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(1, 20)) step($urandom_range(0, 3) == 0);
         vs_pulse($urandom_range(0, 3) == 0, 0);
         wait_idle(1);
         chk_frame_end("rand");
      end

      // write done coincident with frame start, from reset state
      do_reset();
      enable = 1'b1;
      fifo_rand = 1;
      repeat (3) step();
      vs_pulse(1, 0);
      chk_frame_end("coinc");
      wait_idle(0);
      vs_pulse(0, 0);
      chk("coinc_repeat_rd", 32'(rd_buf_sel), 32'(m_rd));
      wait_idle(0);
      chk_frame_end("coinc_end");

      // overrun: command held, vsync arrives mid-frame
      chk("overrun_clear", 32'(err_overrun), 32'd0);
      rdy_mode = 0;
      vs_pulse(0, 0);
      wait_valid();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("hold_addr", cmd_addr, exp_addr);
         chk("hold_len", 32'(cmd_len), 32'(BURST));
      end
      vs_pulse(0, 1);
      chk("err_overrun", 32'(err_overrun), 32'd1);
      rdy_mode = 1;
      wait_idle(0);
      chk_frame_end("overrun");

      // stray beat while idle, outstanding must stay zero
      chk("credit_clear", 32'(err_credit), 32'd0);
      enable = 1'b0;
      repeat (3) step();
      dma_rbeat = 1'b1;
      @(negedge clk);
      dma_rbeat = 1'b0;
      chk("err_credit", 32'(err_credit), 32'd1);
      enable = 1'b1;
      fifo_rand = 0;
      fifo_level = 11'd944;
      rdy_mode = 0;
      repeat (2) step();
      vs_pulse(0, 0);
      step();
      chk("outstanding_zero", 32'(cmd_valid), 32'd1);

      // asynchronous reset while a command is held
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
